// File: rtl/uinst_sequencer_if.sv
// Microinstruction presentation channel between the sequencer and the datapath control decoder.
// Valid/ready handshake carrying the control word and the address it was fetched from.
interface uinst_sequencer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) ();

  logic                  uinst_valid;
  logic                  uinst_ready;
  logic [DATA_WIDTH-1:0] uinst;
  logic [ADDR_WIDTH-1:0] uinst_pc;

  modport master (
    output uinst_valid,
    output uinst,
    output uinst_pc,
    input  uinst_ready
  );

  modport slave (
    input  uinst_valid,
    input  uinst,
    input  uinst_pc,
    output uinst_ready
  );

endinterface

// File: rtl/uinst_sequencer.sv
// Microinstruction sequencer: fetches control-store words from an entry address and
// presents them downstream, following the per-word NEXT/JUMP/LOOP/SETCNT/END sequencing field.
module uinst_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  uinst_sequencer_if.master     uif
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  localparam logic [2:0] SEQ_NEXT   = 3'b000;
  localparam logic [2:0] SEQ_JUMP   = 3'b001;
  localparam logic [2:0] SEQ_LOOP   = 3'b010;
  localparam logic [2:0] SEQ_SETCNT = 3'b011;
  localparam logic [2:0] SEQ_END    = 3'b100;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CNT_WIDTH-1:0]  cnt;

  logic [2:0]            seq;
  logic [ADDR_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0]  count;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  handshake;

  // The ROM output register doubles as the presentation register, so a stall just withholds rom_en.
  assign seq    = rom_dout[DATA_WIDTH-1 -: 3];
  assign target = rom_dout[DATA_WIDTH-4 -: ADDR_WIDTH];
  assign count  = rom_dout[DATA_WIDTH-4-ADDR_WIDTH -: CNT_WIDTH];

  assign busy            = (state != IDLE);
  assign uif.uinst_valid = (state == EXEC);
  assign uif.uinst       = rom_dout;
  assign uif.uinst_pc    = pc;
  assign handshake       = (state == EXEC) && uif.uinst_ready;

  always_comb begin
    next_addr = pc + PC_ONE;
    case (seq)
      SEQ_JUMP: next_addr = target;
      SEQ_LOOP: if (cnt != '0) next_addr = target;
      default:  next_addr = pc + PC_ONE;
    endcase
  end

  always_comb begin
    rom_en   = 1'b0;
    rom_addr = start_addr;
    if (!rst) begin
      case (state)
        IDLE: rom_en = start;
        EXEC: begin
          rom_addr = next_addr;
          rom_en   = handshake && (seq != SEQ_END);
        end
        default: rom_en = 1'b0;
      endcase
    end
  end

  // Reserved seq codes (101-111) fall through as NEXT since only END, SETCNT and LOOP touch extra state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= start_addr;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (handshake) begin
            if (seq == SEQ_END) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              pc <= next_addr;
            end
            if (seq == SEQ_SETCNT) begin
              cnt <= count;
            end else if (seq == SEQ_LOOP && cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
